// File: rtl/irq_request_controller_pkg.sv
// Shared definitions for the interrupt request controller: FSM encoding and the
// decode opcodes it shares with the jump control block.
package irq_request_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FIRE    = 2'd1,
        ST_ENTRY   = 2'd2,
        ST_SERVICE = 2'd3
    } irq_state_e;

    localparam logic [5:0]  OP_JV     = 6'b011100;
    localparam logic [5:0]  OP_JNV    = 6'b011101;
    localparam logic [5:0]  OP_JZ     = 6'b011110;
    localparam logic [5:0]  OP_JNZ    = 6'b011111;
    localparam logic [5:0]  OP_JMP    = 6'b011000;
    localparam logic [5:0]  OP_RET    = 6'b010000;
    localparam logic [15:0] ISR_ENTRY = 16'hF000;

    // Jump control saves current_address+1 as the return address, which is wrong
    // for any instruction that itself redirects the PC.
    function automatic logic is_ctrl_xfer(input logic [5:0] op);
        logic hit;
        case (op)
            OP_JV, OP_JNV, OP_JZ, OP_JNZ, OP_JMP, OP_RET: hit = 1'b1;
            default:                                      hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Lowest-index-wins priority encoder over the masked pending requests.
module irq_priority_enc #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 3
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    id_o
);

    always_comb begin
        valid_o = |req_i;
        id_o    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_request_controller.sv
// Edge-detecting, masked, prioritised interrupt initiator for the jump control block;
// issues a one-cycle pulse and blocks further grants until the ISR's RET reaches decode.
module irq_request_controller
    import irq_request_controller_pkg::*;
#(
    parameter int                 NUM_IRQ   = 8,
    parameter int                 ID_W      = 3,
    parameter logic [NUM_IRQ-1:0] MASK_RST  = 8'hFF,
    parameter int                 ENTRY_CYC = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [5:0]         op_i,
    input  logic               mask_we_i,
    input  logic [NUM_IRQ-1:0] mask_wdata_i,
    output logic               interrupt_o,
    output logic [ID_W-1:0]    irq_id_o,
    output logic               in_service_o,
    output logic [NUM_IRQ-1:0] pending_o
);

    localparam int CNT_W = (ENTRY_CYC > 1) ? $clog2(ENTRY_CYC) : 1;

    logic [NUM_IRQ-1:0] irq_d_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;
    logic               cand_valid;
    logic [ID_W-1:0]    cand_id;
    logic               grant;

    irq_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               interrupt_q;
    logic               in_service_q;
    logic [ID_W-1:0]    irq_id_q;

    irq_priority_enc #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio (
        .req_i   (pending_q & mask_q),
        .valid_o (cand_valid),
        .id_o    (cand_id)
    );

    assign grant = (state_q == ST_IDLE) && cand_valid && !is_ctrl_xfer(op_i);
    assign rise  = irq_i & ~irq_d_q;

    // A fresh rise on the source being granted re-arms it, so rise is OR-ed last.
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pend
        assign clr[gi]       = grant && (cand_id == ID_W'(gi));
        assign pending_d[gi] = rise[gi] | (pending_q[gi] & ~clr[gi]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_d_q   <= '0;
            pending_q <= '0;
            mask_q    <= MASK_RST;
        end else begin
            irq_d_q   <= irq_i;
            pending_q <= pending_d;
            if (mask_we_i) begin
                mask_q <= mask_wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            interrupt_q  <= 1'b0;
            in_service_q <= 1'b0;
            irq_id_q     <= '0;
        end else begin
            interrupt_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        state_q      <= ST_FIRE;
                        interrupt_q  <= 1'b1;
                        in_service_q <= 1'b1;
                        irq_id_q     <= cand_id;
                    end
                end
                ST_FIRE: begin
                    cnt_q   <= CNT_W'(ENTRY_CYC - 1);
                    state_q <= ST_ENTRY;
                end
                // RET is ignored here: the flag save has not completed yet.
                ST_ENTRY: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_SERVICE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_SERVICE: begin
                    if (op_i == OP_RET) begin
                        state_q      <= ST_IDLE;
                        in_service_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign interrupt_o  = interrupt_q;
    assign irq_id_o     = irq_id_q;
    assign in_service_o = in_service_q;
    assign pending_o    = pending_q;

endmodule
